// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   OPCODE / FUNCT3 / FUNCT7 : widths of the decoded instruction fields
//   fetch_state_e            : fetch FSM states
//   resp_pending()           : true in states that own an in-flight imem request
package fetch_unit_pkg;

  localparam int OPCODE = 7;
  localparam int FUNCT3 = 3;
  localparam int FUNCT7 = 7;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,  // one idle cycle after reset release
    ST_FETCH = 2'd1,  // request presented to imem
    ST_WAIT  = 2'd2,  // granted, waiting for the response
    ST_DRAIN = 2'd3   // granted before a redirect, response will be dropped
  } fetch_state_e;

  function automatic logic resp_pending(input fetch_state_e s);
    return (s == ST_WAIT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between imem responses and the decoder.
//   i_clk, i_rst_n           : clock, async active-low reset
//   push, push_instr, push_pc: write one {instr, pc} entry
//   pop                      : consume the head entry
//   flush                    : drop all entries (wins over push/pop)
//   full, empty              : occupancy flags
//   head_instr, head_pc      : head entry, forced to zero while empty
module fetch_buffer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [XLEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc
);

  logic [XLEN-1:0] instr_q [2];
  logic [XLEN-1:0] pc_q    [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            pop_ok;
  logic            push_ok;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign pop_ok = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Zero the head when empty so the decoder never sees flushed data.
  assign head_instr = empty ? '0 : instr_q[rd_ptr];
  assign head_pc    = empty ? '0 : pc_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single-outstanding imem
// request handshake, redirect/flush handling, 2-entry buffer to the decoder.
//   i_clk, i_rst_n                   : clock, async active-low reset
//   o_imem_req, o_imem_addr          : request and word-aligned fetch address
//   i_imem_gnt                       : request accepted this cycle
//   i_imem_rvalid, i_imem_rdata      : one response per grant
//   i_redirect, i_redirect_pc        : taken branch/jump, flush and refetch
//   o_instr_valid, i_instr_ready     : decoder handshake
//   o_instr, o_pc                    : buffer head word and its address
//   o_opcode, o_funct3, o_funct7     : fields sliced from o_instr
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [XLEN-1:0]   i_imem_rdata,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [XLEN-1:0]   o_instr,
  output logic [XLEN-1:0]   o_pc,
  output logic [OPCODE-1:0] o_opcode,
  output logic [FUNCT3-1:0] o_funct3,
  output logic [FUNCT7-1:0] o_funct7
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;  // address of the in-flight request
  logic            gnt_fire;
  logic            still_pending;
  logic            push;
  logic            pop;
  logic            flush;
  logic            buf_full;
  logic            buf_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_BOOT;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
    end
  end

  // Nothing is outstanding in FETCH, so a free buffer slot is the only gate.
  assign o_imem_req  = (state == ST_FETCH) & ~buf_full;
  assign o_imem_addr = pc;
  assign gnt_fire    = o_imem_req & i_imem_gnt;

  // A request still owes a response after this cycle if it was just granted,
  // or was already in flight and its response is not arriving now. Going to
  // DRAIN without a response still owed would stall forever.
  assign still_pending = gnt_fire | (resp_pending(state) & ~i_imem_rvalid);

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    push     = 1'b0;
    flush    = 1'b0;
    case (state)
      ST_BOOT:  state_n = ST_FETCH;
      ST_FETCH: begin
        if (gnt_fire) begin
          pc_n     = pc + XLEN'(4);
          req_pc_n = pc;
          state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          push    = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) state_n = ST_FETCH;
      end
      default: state_n = ST_BOOT;
    endcase
    // Redirect overrides everything above.
    if (i_redirect) begin
      flush   = 1'b1;
      push    = 1'b0;
      pc_n    = i_redirect_pc & ~XLEN'(3);
      state_n = still_pending ? ST_DRAIN : ST_FETCH;
    end
  end

  assign pop = o_instr_valid & i_instr_ready;

  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .push       (push),
    .push_instr (i_imem_rdata),
    .push_pc    (req_pc),
    .pop        (pop),
    .flush      (flush),
    .full       (buf_full),
    .empty      (buf_empty),
    .head_instr (o_instr),
    .head_pc    (o_pc)
  );

  assign o_instr_valid = ~buf_empty;
  assign o_opcode      = o_instr[6:0];
  assign o_funct3      = o_instr[14:12];
  assign o_funct7      = o_instr[31:25];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: XLEN, default 32, address/instruction width.
REQ-003 i_clk  input  1  single clock, all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 o_imem_req  output  1  instruction-memory request valid.
REQ-006 o_imem_addr  output  XLEN  word-aligned fetch address, stable while o_imem_req=1 and i_imem_gnt=0.
REQ-007 i_imem_gnt  input  1  request accepted this cycle.
REQ-008 i_imem_rvalid  input  1  response data valid, exactly one per grant, at least 1 cycle after grant.
REQ-009 i_imem_rdata  input  XLEN  fetched instruction word.
REQ-010 i_redirect  input  1  branch/jump taken, flush and refetch.
REQ-011 i_redirect_pc  input  XLEN  redirect target.
REQ-012 o_instr_valid  output  1  instruction available to the decoder.
REQ-013 i_instr_ready  input  1  decoder consumes instruction when valid and ready are both 1.
REQ-014 o_instr  output  XLEN  instruction word at buffer head.
REQ-015 o_pc  output  XLEN  address of o_instr.
REQ-016 o_opcode / o_funct3 / o_funct7  output  OPCODE/FUNCT3/FUNCT7  instr[6:0], [14:12], [31:25] of o_instr.

Function
REQ-017 FSM states: BOOT (one cycle after reset release, no request), FETCH (o_imem_req=1), WAIT (one request outstanding), DRAIN (discarding stale response).
REQ-018 At most one outstanding request; a request is issued in FETCH only when buffer occupancy + outstanding < 2.
REQ-019 On grant: fetch PC += 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000; FSM -> WAIT.
REQ-020 On i_imem_rvalid in WAIT: {rdata, pc} written to 2-entry buffer; FSM -> FETCH.
REQ-021 o_instr_valid = buffer not empty; o_instr/o_pc/fields come from buffer head combinationally.
REQ-022 Best-case latency: grant at cycle N, rvalid at N+1, o_instr_valid at N+2.
REQ-023 Simultaneous buffer write and decoder pop on a full buffer: pop first, write succeeds, no loss.
REQ-024 i_redirect has priority over every other event in the same cycle.
REQ-025 On i_redirect: buffer flushed (o_instr_valid=0 next cycle); fetch PC <= {i_redirect_pc[XLEN-1:2], 2'b00}.
REQ-026 Redirect with a request outstanding (WAIT, or FETCH with gnt same cycle): FSM -> DRAIN; the next rvalid is discarded, then -> FETCH.
REQ-027 Redirect with no outstanding request: FSM -> FETCH; the redirect-target request is presented the next cycle.
REQ-028 Redirect during DRAIN: PC updated, remains in DRAIN.
REQ-029 i_imem_rvalid outside WAIT/DRAIN is ignored.

Reset
REQ-030 While i_rst_n=0: FSM=BOOT, fetch PC=RESET_PC, buffer empty, outstanding=0, o_imem_req=0, o_instr_valid=0, o_imem_addr=RESET_PC, o_instr=0, o_pc=0.
REQ-031 Reset asserted mid-transaction abandons the outstanding request; responses after release are ignored until the first post-reset grant.

Structure
REQ-032 OPCODE, FUNCT3, FUNCT7 width constants and the fetch FSM state enum are defined in the shared define header/package.
REQ-033 Buffer implemented as sub-module fetch_buffer (2-entry FIFO, push/pop/flush, full/empty); FSM and PC stay in fetch_unit.

Verification
REQ-034 Reset release, RESET_PC=0, gnt=1 always, rvalid 1 cycle later, ready=1 -> pcs 0x0, 0x4, 0x8 delivered in order; first o_instr_valid 3 cycles after release.
REQ-035 ready=0 for 10 cycles -> exactly 2 instructions buffered, o_imem_req=0 afterwards; no duplicate or lost pc when ready returns.
REQ-036 Redirect to 0x100 while request to 0x8 outstanding -> 0x8 response discarded, next delivered o_pc=0x100, o_instr_valid=0 for the cycle after redirect.
REQ-037 Redirect to 0x203 -> fetch address 0x200.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> delivered pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-039 i_rst_n pulled low while in WAIT, stale rvalid arriving after release -> ignored; first delivered o_pc=RESET_PC.
